// File: rtl/carregador_programa_pkg.sv
// Shared types and constants for the boot-time program loader.
package carregador_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int HDR_BYTES         = 2;
  localparam int BYTES_PER_WORD    = 4;
  localparam int MAX_WORDS_DEFAULT = 128;

  // A word count is usable when it is non-zero and fits in memory.
  function automatic logic count_ok(input logic [15:0] n, input logic [15:0] max_n);
    return (n != 16'd0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/carregador_programa_if.sv
// Host byte stream plus memory write port seen by the loader.
interface carregador_programa_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] dado;
  logic [ADDR_W-1:0] endereco;
  logic              write;

  // master: the loader; slave: host + instruction memory side
  modport master (
    input  byte_in, byte_valid,
    output byte_ready, dado, endereco, write
  );
  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, dado, endereco, write
  );
endinterface

// File: rtl/carregador_programa_montador_palavra.sv
// Big-endian word assembler with a running XOR over every loaded byte.
module montador_palavra
  import carregador_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_full,
  output logic [7:0]  o_checksum
);

  logic [23:0] r_shift;
  logic [1:0]  r_count;
  logic [7:0]  r_xor;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_shift <= '0;
      r_count <= '0;
      r_xor   <= '0;
    end else if (i_load) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_count <= r_count + 2'd1;
      r_xor   <= r_xor ^ i_byte;
    end
  end

  // The word including the byte being accepted right now, so the top can
  // register it on the same edge that completes it.
  assign o_word_next = {r_shift, i_byte};
  assign o_word_full = i_load && (r_count == 2'(BYTES_PER_WORD - 1));
  assign o_checksum  = r_xor;

endmodule

// File: rtl/carregador_programa.sv
// Program loader: header, word assembly, memory writes and checksum gate on CPU reset.
module carregador_programa
  import carregador_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  carregador_programa_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  erro,
  output logic                  cpu_reset
);

  localparam logic [15:0] MAX_N     = 16'(MAX_WORDS);
  localparam int          HDR_CNT_W = $clog2(HDR_BYTES);

  state_t r_state, w_state_next;

  logic [HDR_CNT_W-1:0] r_hdr_cnt;
  logic [15:0]          r_n;
  logic [15:0]          r_index;

  logic              r_byte_ready, r_write, r_busy, r_done, r_erro, r_cpu_reset;
  logic [DATA_W-1:0] r_dado;
  logic [ADDR_W-1:0] r_endereco;

  logic        w_accept, w_start_go, w_hdr_last, w_load;
  logic [15:0] w_n, w_index_inc;
  logic [31:0] w_word_next;
  logic        w_word_full;
  logic [7:0]  w_checksum;

  assign w_accept    = bus.byte_valid && r_byte_ready;
  assign w_start_go  = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_hdr_last  = (r_hdr_cnt == HDR_CNT_W'(HDR_BYTES - 1));
  assign w_n         = {r_n[7:0], bus.byte_in};
  assign w_index_inc = r_index + 16'd1;
  assign w_load      = w_accept && (r_state == S_DATA);

  montador_palavra u_montador (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_clear     (w_start_go),
    .i_load      (w_load),
    .i_byte      (bus.byte_in),
    .o_word_next (w_word_next),
    .o_word_full (w_word_full),
    .o_checksum  (w_checksum)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) w_state_next = S_HEADER;
      S_HEADER:
        if (w_accept && w_hdr_last)
          w_state_next = count_ok(w_n, MAX_N) ? S_DATA : S_ERROR;
      S_DATA:
        if (w_word_full) w_state_next = S_WRITE;
      S_WRITE:
        w_state_next = (w_index_inc < r_n) ? S_DATA : S_CHECK;
      S_CHECK:
        if (w_accept)
          w_state_next = (bus.byte_in == w_checksum) ? S_DONE : S_ERROR;
      default:
        w_state_next = S_IDLE;
    endcase
  end

  // Header shift and word index; r_n holds N once the header is complete.
  always_ff @(posedge clock) begin
    if (reset || w_start_go) begin
      r_hdr_cnt <= '0;
      r_n       <= '0;
      r_index   <= '0;
    end else begin
      if (r_state == S_HEADER && w_accept) begin
        r_n       <= w_n;
        r_hdr_cnt <= r_hdr_cnt + 1'b1;
      end
      if (r_state == S_WRITE) r_index <= w_index_inc;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_ready <= 1'b0;
      r_write      <= 1'b0;
      r_dado       <= '0;
      r_endereco   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_erro       <= 1'b0;
      r_cpu_reset  <= 1'b0;
    end else begin
      r_byte_ready <= w_state_next inside {S_HEADER, S_DATA, S_CHECK};
      r_write      <= (w_state_next == S_WRITE);
      r_busy       <= w_state_next inside {S_HEADER, S_DATA, S_WRITE, S_CHECK};
      r_cpu_reset  <= w_state_next inside {S_HEADER, S_DATA, S_WRITE, S_CHECK, S_ERROR};
      r_done       <= (w_state_next == S_DONE);
      r_erro       <= (w_state_next == S_ERROR);
      if (w_state_next == S_WRITE) begin
        r_dado     <= w_word_next;
        r_endereco <= r_index[ADDR_W-1:0];
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.write      = r_write;
  assign bus.dado       = r_dado;
  assign bus.endereco   = r_endereco;
  assign busy           = r_busy;
  assign done           = r_done;
  assign erro           = r_erro;
  assign cpu_reset      = r_cpu_reset;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench: directed spec streams, a vector table and random loads vs a stream model.
module tb_carregador_programa;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 128;
  localparam int BUDGET    = 5000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, erro, cpu_reset;

  carregador_programa_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  carregador_programa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .erro      (erro),
    .cpu_reset (cpu_reset)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic              prev_write = 1'b0;

  typedef struct {
    int   n_hdr;
    int   mode;       // 0: word value = index, 1: random words
    logic corrupt;
    int   gap;        // percent chance of an idle byte slot
    logic exp_done;
    logic exp_erro;
    int   exp_writes;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Memory-side monitor: records every write and checks it lasts one cycle.
  always @(posedge clock) begin
    #1;
    if (bus.write === 1'b1) begin
      got_addr.push_back(bus.endereco);
      got_data.push_back(bus.dado);
      tests++;
      if (prev_write) begin
        fails++;
        $display("FAIL write_pulse: write high on consecutive cycles at addr %0d, expected 1 cycle", bus.endereco);
      end
    end
    prev_write <= (bus.write === 1'b1);
  end

  // Reference: interpret a byte stream by the loader's rules.
  task automatic model(input logic [7:0] s[$], output logic [31:0] w[$],
                       output logic d, output logic e, output int consumed);
    int n;
    logic [7:0] x;
    n = int'(s[0]) * 256 + int'(s[1]);
    x = 8'h00;
    w.delete();
    if (n == 0 || n > MAX_WORDS) begin
      d = 1'b0; e = 1'b1; consumed = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w.push_back({s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
      x = x ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
    end
    d = (s[2+4*n] == x);
    e = !d;
    consumed = 3 + 4 * n;
  endtask

  task automatic make_stream(input int n_hdr, input int mode, input logic corrupt,
                             output logic [7:0] s[$]);
    int nw;
    logic [7:0] x;
    logic [31:0] word;
    nw = (n_hdr >= 1 && n_hdr <= MAX_WORDS) ? n_hdr : 1;
    x = 8'h00;
    s.delete();
    s.push_back(8'(n_hdr >> 8));
    s.push_back(8'(n_hdr));
    for (int k = 0; k < nw; k++) begin
      word = (mode == 0) ? 32'(k) : $urandom();
      for (int b = 3; b >= 0; b--) begin
        s.push_back(word[8*b +: 8]);
        x = x ^ word[8*b +: 8];
      end
    end
    s.push_back(corrupt ? ~x : x);
  endtask

  // Drives a load; stops after stop_after bytes, or (stop_after<0) when done/erro rise.
  task automatic run(input logic [7:0] s[$], input int gap, input int stop_after,
                     output int consumed, output int lag);
    int idx, cyc, last_cyc, limit;
    logic ready_seen;
    idx = 0; cyc = 0; last_cyc = 0;
    limit = (stop_after >= 0 && stop_after < s.size()) ? stop_after : s.size();
    got_addr.delete();
    got_data.delete();
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (cyc < BUDGET) begin
      if (idx < limit) begin
        if (!bus.byte_valid) bus.byte_valid = ($urandom_range(99) >= gap);
        bus.byte_in = s[idx];
      end else begin
        bus.byte_valid = 1'b0;
      end
      ready_seen = bus.byte_ready;
      @(posedge clock); #1;
      cyc++;
      if (bus.byte_valid && ready_seen) begin
        idx++;
        last_cyc = cyc;
        bus.byte_valid = 1'b0;
      end
      if (stop_after >= 0) begin
        if (idx >= stop_after) break;
      end else if (done || erro) begin
        break;
      end
    end
    bus.byte_valid = 1'b0;
    if (cyc >= BUDGET) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d bytes consumed after %0d cycles, load did not finish", idx, cyc);
    end
    consumed = idx;
    lag = cyc - last_cyc;
  endtask

  task automatic do_load(input logic [7:0] s[$], input int gap, input string tag);
    logic [31:0] ew[$];
    logic ed, ee;
    int ec, consumed, lag;
    model(s, ew, ed, ee, ec);
    run(s, gap, -1, consumed, lag);
    $display("[TB] load %s: N=%0d writes=%0d done=%0b erro=%0b consumed=%0d",
             tag, int'(s[0]) * 256 + int'(s[1]), got_data.size(), done, erro, consumed);
    check({tag, "_nwrites"}, 32'(got_data.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), got_data[i], ew[i]);
    end
    check({tag, "_done"}, 32'(done), 32'(ed));
    check({tag, "_erro"}, 32'(erro), 32'(ee));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(ee));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(0));
    check({tag, "_consumed"}, 32'(consumed), 32'(ec));
    check({tag, "_status_lag"}, 32'(lag), 32'(0));
    if (ew.size() > 0) begin
      check({tag, "_dado_hold"}, bus.dado, ew[ew.size()-1]);
      check({tag, "_end_hold"}, 32'(bus.endereco), 32'(ew.size() - 1));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_erro"}, 32'(erro), 32'(0));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(0));
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(0));
    check({tag, "_write"}, 32'(bus.write), 32'(0));
    check({tag, "_dado"}, bus.dado, 32'(0));
    check({tag, "_endereco"}, 32'(bus.endereco), 32'(0));
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] s[$];
    vec_t vecs[8];
    int consumed, lag, n, gap;
    logic corrupt;

    good = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    vecs = '{
      '{1,   1, 1'b0, 0,  1'b1, 1'b0, 1},
      '{3,   1, 1'b0, 40, 1'b1, 1'b0, 3},
      '{5,   1, 1'b1, 20, 1'b0, 1'b1, 5},
      '{0,   1, 1'b0, 0,  1'b0, 1'b1, 0},
      '{129, 1, 1'b0, 0,  1'b0, 1'b1, 0},
      '{256, 1, 1'b0, 10, 1'b0, 1'b1, 0},
      '{128, 0, 1'b0, 0,  1'b1, 1'b0, 128},
      '{128, 1, 1'b0, 30, 1'b1, 1'b0, 128}
    };

    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clock); #1;

    do_load(good, 0, "good");
    check("good_word0", got_data.size() > 0 ? got_data[0] : 32'hDEAD_BEEF, 32'h1234_5678);
    check("good_word1", got_data.size() > 1 ? got_data[1] : 32'hDEAD_BEEF, 32'h9ABC_DEF0);

    s = good;
    s[10] = 8'hFF;
    do_load(s, 0, "badchk");
    check("badchk_word1", got_data.size() > 1 ? got_data[1] : 32'hDEAD_BEEF, 32'h9ABC_DEF0);

    s = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    do_load(s, 0, "n0");
    s = '{8'h00, 8'h81, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    do_load(s, 0, "n129");

    // start together with reset: reset must win, leaving ERROR and not entering HEADER
    start = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b0;
    check_reset_values("start_rst");

    for (int i = 0; i < 8; i++) begin
      make_stream(vecs[i].n_hdr, vecs[i].mode, vecs[i].corrupt, s);
      do_load(s, vecs[i].gap, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_tbl_erro", i), 32'(erro), 32'(vecs[i].exp_erro));
      check($sformatf("vec%0d_tbl_writes", i), 32'(got_data.size()), 32'(vecs[i].exp_writes));
    end
    check("full_last_addr", got_addr.size() > 0 ? 32'(got_addr[got_addr.size()-1]) : 32'hFFFF, 32'd127);

    // reset after the second data byte, then a clean reload
    run(good, 0, 4, consumed, lag);
    check("midrst_consumed", 32'(consumed), 32'd4);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_reset_values("midrst");
    do_load(good, 0, "reload");
    check("reload_word0", got_data.size() > 0 ? got_data[0] : 32'hDEAD_BEEF, 32'h1234_5678);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 12);
      corrupt = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 60);
      make_stream(n, 1, corrupt, s);
      do_load(s, gap, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Boot-time program loader that sits directly upstream of the processor's 32-bit instruction/data memory. It accepts a byte stream from a host link, assembles big-endian 32-bit words, and writes them into consecutive memory addresses from 0. It holds the CPU in reset while loading and verifies an XOR checksum before releasing it.

## Interface
Parameters:
- ADDR_W, 10: width of memory address output.
- DATA_W, 32: memory word width (fixed at 32; 4 bytes per word).
- MAX_WORDS, 128: memory depth; largest legal word count.

Ports:
- clock  in  1  single clock; memory write port shares it.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load.
- byte_in  in  8  host byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- dado  out  DATA_W  word to memory.
- endereco  out  ADDR_W  memory word address.
- write  out  1  memory write strobe; one cycle per word.
- busy  out  1  load in progress.
- done  out  1  load completed with a good checksum.
- erro  out  1  load aborted (bad count or checksum).
- cpu_reset  out  1  holds the processor in reset.

## Operation
- States: IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR.
- A byte is accepted on a rising edge with byte_valid && byte_ready. byte_ready=1 only in HEADER, DATA and CHECK.
- IDLE/DONE/ERROR + start → HEADER. Entering HEADER clears the word index, byte counter, checksum, done and erro. start in any other state is ignored.
- HEADER: 2 bytes give the word count N, big-endian 16-bit.
  - N==0 or N>MAX_WORDS → ERROR after the 2nd byte.
  - Otherwise → DATA.
- DATA: 4 bytes per word, first byte = dado[31:24]. After the 4th byte → WRITE.
- WRITE: write=1 for exactly this cycle, with endereco=index and dado=the assembled word. Then index++. → DATA if index<N, else CHECK.
- Checksum: 8-bit XOR of every DATA byte; header bytes are excluded.
- CHECK: 1 byte. Match → DONE, else → ERROR.
- Outputs by state:
  - busy=1 in HEADER, DATA, WRITE, CHECK.
  - cpu_reset=1 in HEADER, DATA, WRITE, CHECK and ERROR; 0 in IDLE and DONE.
  - done=1 only in DONE; erro=1 only in ERROR. Both hold until the next start.
- Words already written before an ERROR stay in memory; there is no rollback.
- Reset mid-load: next cycle is IDLE with all outputs at reset values. The partial program remains in memory.

## Timing
- Reset values: state IDLE, byte_ready 0, write 0, dado 0, endereco 0, busy 0, done 0, erro 0, cpu_reset 0.
- All outputs are registered.
- write rises the cycle after the 4th byte of a word is accepted. dado and endereco are stable during that cycle and remain unchanged until the next write.
- byte_ready=0 during WRITE. A byte presented then must be held by the host and is accepted in the next DATA cycle.
- Peak throughput is 1 word per 5 cycles.
- done/erro rise the cycle after the checksum byte, or after the 2nd header byte for a bad N.
- start and reset in the same cycle: reset wins.

## Structure
- Package carregador_pkg:
  - state enum
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
  - default MAX_WORDS
- Sub-module montador_palavra: shift register with a 2-bit byte counter and a running XOR. It reports word_full and provides checksum.
- Top level contains the FSM, word index/count registers and output registers.

## Test plan
- Good load: start, bytes 00 02 12 34 56 78 9A BC DE F0 00 → write@0=0x12345678, write@1=0x9ABCDEF0, done=1, erro=0, cpu_reset=0.
- Bad checksum: same stream with final byte FF → both writes occur, erro=1, done=0, cpu_reset=1.
- Bad count: header 00 00, and separately 00 81 → erro=1 after the 2nd byte, no write pulse, byte_ready=0.
- Full memory: N=128 (00 80), words with value = index → last write at endereco=127, done=1.
- Handshake: random byte_valid gaps, and valid held high through WRITE cycles → no byte lost or duplicated, each write exactly 1 cycle, word values exact.
- Reset after the 2nd DATA byte → next cycle matches all reset values. A fresh start with the good-load stream yields done=1 and correct words at 0 and 1.
